// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the parametrised pipeline stall controller.
//   state_t    : controller FSM states
//   DEF_*_OP   : default opcodes for load, jump and halt
//   DEF_*_STALL: default stall lengths for load and jump
//   stall_len(): stall cycle count for a decoded opcode (halt handled separately)
package stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    RELEASE = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [5:0] DEF_LD_OP  = 6'b010100;
  localparam logic [5:0] DEF_JMP_OP = 6'b011110;
  localparam logic [5:0] DEF_HLT_OP = 6'b010001;

  localparam int unsigned DEF_LD_STALL  = 1;
  localparam int unsigned DEF_JMP_STALL = 2;

  // Opcodes are passed zero-extended to 32 bits so one function serves any OPW.
  // Jump is checked before load to keep the JMP > LD priority.
  function automatic int unsigned stall_len(
    input logic [31:0] op,
    input logic [31:0] ld_op     = 32'(DEF_LD_OP),
    input logic [31:0] jmp_op    = 32'(DEF_JMP_OP),
    input int unsigned ld_stall  = DEF_LD_STALL,
    input int unsigned jmp_stall = DEF_JMP_STALL
  );
    if (op == jmp_op)
      return jmp_stall;
    else if (op == ld_op)
      return ld_stall;
    else
      return 0;
  endfunction

endpackage

// File: rtl/stall_down_counter.sv
// Down counter used to time the STALL state.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (count -> 0)
//   load     : load load_val (takes priority over dec)
//   load_val : value to load
//   dec      : decrement by one; holds at zero, never wraps
//   zero     : count is zero
module stall_down_counter
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned CNTW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [CNTW-1:0] load_val,
  input  logic            dec,
  output logic            zero
);

  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - CNTW'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/stall_control_param.sv
// Pipeline stall controller. Decodes the IF/ID opcode and freezes fetch for a
// per-class number of cycles (load, jump) or until resume (halt).
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   op        : opcode from IF/ID (held by the pipeline while stalled + 1 cycle)
//   hazard_in : external stall request, ORed into stall
//   resume    : leave HALT (sampled only in HALT)
//   stall     : freeze PC and IF/ID
//   stall_pm  : stall delayed one clock, program-memory disable
//   halted    : controller is in HALT
module stall_control_param
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned     OPW       = 6,
  parameter logic [OPW-1:0]  LD_OP     = DEF_LD_OP,
  parameter logic [OPW-1:0]  JMP_OP    = DEF_JMP_OP,
  parameter logic [OPW-1:0]  HLT_OP    = DEF_HLT_OP,
  parameter int unsigned     LD_STALL  = DEF_LD_STALL,
  parameter int unsigned     JMP_STALL = DEF_JMP_STALL,
  parameter int unsigned     CNTW      = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic           hazard_in,
  input  logic           resume,
  output logic           stall,
  output logic           stall_pm,
  output logic           halted
);

  // Stall counts must fit in the counter so it can never wrap.
  if ((LD_STALL >> CNTW) != 0) begin : g_bad_ld_stall
    $error("LD_STALL does not fit in CNTW bits");
  end
  if ((JMP_STALL >> CNTW) != 0) begin : g_bad_jmp_stall
    $error("JMP_STALL does not fit in CNTW bits");
  end

  state_t          state_q, state_d;
  logic            fsm_stall;
  logic            cnt_load;
  logic            cnt_dec;
  logic [CNTW-1:0] cnt_val;
  logic            cnt_zero;
  logic [31:0]     len;

  assign len = stall_len(32'(op), 32'(LD_OP), 32'(JMP_OP), LD_STALL, JMP_STALL);

  stall_down_counter #(.CNTW(CNTW)) u_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  // The trigger cycle in RUN is the first stalled cycle, so the counter is
  // loaded with N-2: the STALL state then covers the remaining N-1 cycles.
  always_comb begin
    state_d   = state_q;
    fsm_stall = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;
    case (state_q)
      RUN: begin
        if (op == HLT_OP) begin
          fsm_stall = 1'b1;
          state_d   = HALT;
        end else if (len != 0) begin
          fsm_stall = 1'b1;
          if (len == 1) begin
            state_d = RELEASE;
          end else begin
            state_d  = STALL;
            cnt_load = 1'b1;
            cnt_val  = CNTW'(len - 32'd2);
          end
        end
      end
      STALL: begin
        fsm_stall = 1'b1;
        if (cnt_zero)
          state_d = RELEASE;
        else
          cnt_dec = 1'b1;
      end
      // op still holds the instruction that caused the stall; do not decode it.
      RELEASE: begin
        state_d = RUN;
      end
      HALT: begin
        fsm_stall = 1'b1;
        if (resume)
          state_d = RELEASE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Outputs are gated by reset so they drop immediately on an asynchronous reset.
  assign stall  = reset & (fsm_stall | hazard_in);
  assign halted = reset & (state_q == HALT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_pm <= 1'b0;
    else
      stall_pm <= stall;
  end

endmodule
